// File: rtl/microplexer_cfg_loader.sv
// Configuration loader for a bank of microplexers: hunts for a sync byte, assembles
// packed 4-bit select masks, verifies an XOR checksum and commits all masks in one edge.
module microplexer_cfg_loader #(
    parameter int NUM_MUX = 8,
    parameter int SEL_W   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               cfg_data,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    output logic [NUM_MUX*SEL_W-1:0] sel_flat,
    output logic                     cfg_loaded,
    output logic                     cfg_done,
    output logic                     cfg_err
);

    localparam int               NUM_BYTES = NUM_MUX / 2;
    localparam int               CNT_W     = $clog2(NUM_BYTES) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_BYTES - 1);
    localparam logic [7:0]       SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        S_HUNT,
        S_LOAD,
        S_CHECK,
        S_COMMIT
    } state_t;

    state_t                     r_state;
    logic [CNT_W-1:0]           r_cnt;
    logic [7:0]                 r_xor;
    logic [NUM_MUX*SEL_W-1:0]   r_shadow;
    logic [NUM_MUX*SEL_W-1:0]   r_sel;
    logic                       r_ready;
    logic                       r_loaded;
    logic                       r_done;
    logic                       r_err;
    logic                       w_accept;

    assign w_accept   = cfg_valid & r_ready;
    assign cfg_ready  = r_ready;
    assign sel_flat   = r_sel;
    assign cfg_loaded = r_loaded;
    assign cfg_done   = r_done;
    assign cfg_err    = r_err;

    // NOTE: all state, including the shadow mask, is updated with non-blocking
    // assignments so every register samples pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_HUNT;
            r_cnt    <= '0;
            r_xor    <= '0;
            r_shadow <= '0;
            r_sel    <= '0;
            r_ready  <= 1'b0;
            r_loaded <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_ready <= 1'b1;
            case (r_state)
                S_HUNT: begin
                    if (w_accept && cfg_data == SYNC_BYTE) begin
                        r_state <= S_LOAD;
                        r_cnt   <= '0;
                        r_xor   <= '0;
                    end
                end
                S_LOAD: begin
                    // A sync value inside the payload is ordinary data: no resync here.
                    if (w_accept) begin
                        r_shadow[8*r_cnt +: 8] <= cfg_data;
                        r_xor                  <= r_xor ^ cfg_data;
                        r_cnt                  <= r_cnt + 1'b1;
                        if (r_cnt == LAST_IDX) begin
                            r_state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_accept) begin
                        if (cfg_data == r_xor) begin
                            r_state <= S_COMMIT;
                            r_ready <= 1'b0;
                        end else begin
                            r_state  <= S_HUNT;
                            r_err    <= 1'b1;
                            r_shadow <= '0;
                        end
                    end
                end
                S_COMMIT: begin
                    r_sel    <= r_shadow;
                    r_loaded <= 1'b1;
                    r_done   <= 1'b1;
                    r_state  <= S_HUNT;
                end
                default: begin
                    r_state <= S_HUNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_microplexer_cfg_loader.sv
// Scoreboard bench: a frame-level model predicts commit/error events from the accepted
// byte stream; an independent monitor checks them whenever cfg_done or cfg_err fires.
module tb_microplexer_cfg_loader;

    localparam int NUM_MUX = 8;
    localparam int NB      = NUM_MUX / 2;
    localparam int SW      = NUM_MUX * 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    cfg_data;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [SW-1:0] sel_flat;
    logic          cfg_loaded;
    logic          cfg_done;
    logic          cfg_err;

    microplexer_cfg_loader #(.NUM_MUX(NUM_MUX), .SEL_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_data   (cfg_data),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .sel_flat   (sel_flat),
        .cfg_loaded (cfg_loaded),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_err;
        logic [SW-1:0] sel;
        bit            loaded;
    } event_t;

    event_t    sb_q[$];
    int        n_cmp  = 0;
    int        n_fail = 0;

    // Reference model state: frame-level view of the accepted byte stream.
    bit            m_in_frame;
    logic [7:0]    m_bytes[$];
    logic [SW-1:0] m_sel;
    bit            m_loaded;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 0;
        m_bytes.delete();
        m_sel      = '0;
        m_loaded   = 0;
    endtask

    task automatic model_accept(input logic [7:0] b);
        logic [7:0]    x;
        logic [SW-1:0] s;
        event_t        ev;
        if (!m_in_frame) begin
            if (b == 8'hA5) begin
                m_in_frame = 1;
                m_bytes.delete();
            end
        end else begin
            m_bytes.push_back(b);
            if (m_bytes.size() == NB + 1) begin
                x = 8'h00;
                for (int j = 0; j < NB; j++) x ^= m_bytes[j];
                if (x == m_bytes[NB]) begin
                    s = '0;
                    for (int j = 0; j < NB; j++) begin
                        s[4*(2*j)   +: 4] = m_bytes[j][3:0];
                        s[4*(2*j+1) +: 4] = m_bytes[j][7:4];
                    end
                    m_sel    = s;
                    m_loaded = 1;
                    ev.is_err = 0;
                end else begin
                    ev.is_err = 1;
                end
                ev.sel    = m_sel;
                ev.loaded = m_loaded;
                sb_q.push_back(ev);
                m_in_frame = 0;
            end
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send_byte(input logic [7:0] b, input bit allow_gap);
        int n;
        if (allow_gap && $urandom_range(0, 2) == 0) begin
            cfg_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        cfg_data  = b;
        cfg_valid = 1'b1;
        n = 0;
        while (cfg_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (cfg_ready !== 1'b1) begin
            check("ready_timeout", {63'd0, cfg_ready}, 64'd1);
            cfg_valid = 1'b0;
        end else begin
            model_accept(b);
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] p[NB], input bit corrupt, input bit gaps);
        logic [7:0] x;
        x = 8'h00;
        send_byte(8'hA5, gaps);
        for (int j = 0; j < NB; j++) begin
            send_byte(p[j], gaps);
            x ^= p[j];
        end
        send_byte(corrupt ? (x ^ 8'(1 << $urandom_range(0, 7))) : x, gaps);
    endtask

    task automatic idle(input int n);
        cfg_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset(input int n);
        cfg_valid = 1'b0;
        reset     = 1'b1;
        repeat (n) @(negedge clk);
        check("rst_sel", 64'(sel_flat), 64'd0);
        check("rst_loaded", {63'd0, cfg_loaded}, 64'd0);
        check("rst_ready", {63'd0, cfg_ready}, 64'd0);
        check("rst_pulses", {62'd0, cfg_done, cfg_err}, 64'd0);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic check_state(input string name);
        check({name, "_sel"}, 64'(sel_flat), 64'(m_sel));
        check({name, "_loaded"}, {63'd0, cfg_loaded}, {63'd0, m_loaded});
    endtask

    // Monitor: every pulse must match the oldest predicted event.
    always @(negedge clk) begin
        event_t ev;
        if (reset === 1'b0 && (cfg_done === 1'b1 || cfg_err === 1'b1)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", {62'd0, cfg_done, cfg_err}, 64'd0);
            end else begin
                ev = sb_q.pop_front();
                check("mon_kind", {62'd0, cfg_done, cfg_err}, ev.is_err ? 64'd1 : 64'd2);
                check("mon_sel", 64'(sel_flat), 64'(ev.sel));
                check("mon_loaded", {63'd0, cfg_loaded}, {63'd0, ev.loaded});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] p[NB];
        logic [7:0] junk;
        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        model_reset();
        @(negedge clk);
        apply_reset(3);

        // 1: basic frame, commit timing and one-cycle ready drop
        p = '{8'h21, 8'h43, 8'h65, 8'h87};
        send_frame(p, 0, 0);
        cfg_valid = 1'b0;
        check("t1_ready_commit", {63'd0, cfg_ready}, 64'd0);
        @(negedge clk);
        check("t1_ready_after", {63'd0, cfg_ready}, 64'd1);
        check("t1_done", {63'd0, cfg_done}, 64'd1);
        idle(2);
        check_state("t1");
        check("t1_model_sel", 64'(m_sel), 64'h87654321);

        // 2: bad checksum leaves previous configuration in place
        p = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_byte(8'hA5, 0);
        for (int j = 0; j < NB; j++) send_byte(p[j], 0);
        send_byte(8'h81, 0);
        idle(3);
        check_state("t2");

        // 3: leading junk is discarded while hunting
        send_byte(8'h00, 0);
        send_byte(8'h5A, 0);
        send_byte(8'h13, 0);
        p = '{8'h11, 8'h11, 8'h11, 8'h11};
        send_frame(p, 0, 0);
        idle(3);
        check_state("t3");

        // 4: sync value as payload, with random valid gaps
        p = '{8'hA5, 8'hA5, 8'hA5, 8'hA5};
        send_frame(p, 0, 1);
        idle(3);
        check_state("t4");

        // 5: reset in the middle of a frame, then a normal frame
        send_byte(8'hA5, 0);
        send_byte(8'h3C, 0);
        send_byte(8'hC3, 0);
        apply_reset(2);
        check_state("t5_rst");
        p = '{8'h9E, 8'h01, 8'hB7, 8'h42};
        send_frame(p, 0, 0);
        idle(3);
        check_state("t5");

        // 6: back-to-back frames with valid held high
        p = '{8'h12, 8'h34, 8'h56, 8'h78};
        send_frame(p, 0, 0);
        p = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_frame(p, 0, 0);
        idle(3);
        check_state("t6");

        // Random frames: junk, corrupt checksums, gaps
        for (int f = 0; f < 16; f++) begin
            repeat ($urandom_range(0, 2)) begin
                junk = 8'($urandom);
                if (junk == 8'hA5) junk = 8'h00;
                send_byte(junk, 1);
            end
            for (int j = 0; j < NB; j++) p[j] = 8'($urandom);
            send_frame(p, ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
        end
        idle(4);
        check_state("rand");
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/microplexer_cfg_loader.md
Name: microplexer_cfg_loader

Overview:
- Writer side of the microplexer select interface: receives a byte-wide configuration stream, assembles per-microplexer 4-bit select masks, and drives them onto the sel4 inputs of a bank of NUM_MUX microplexers.
- Frames are checked by an XOR checksum before use.
- Masks are committed atomically, so the microplexer fabric never sees a partially loaded configuration.
- Sits between the host config port (UART/bus bridge) and the microplexer array.

Parameters:
- NUM_MUX, 8, number of microplexers driven. Must be even and >= 2.
- SEL_W, 4, select-mask width per microplexer. Fixed at 4; two masks are packed per byte.

Ports:
- clk  input  1  single system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- cfg_data  input  8  configuration byte from the host.
- cfg_valid  input  1  cfg_data is valid this cycle.
- cfg_ready  output  1  loader accepts a byte this cycle. A byte transfers on a clock edge when cfg_valid and cfg_ready are both high.
- sel_flat  output  NUM_MUX*4  active select masks; bits [4k+3:4k] drive sel4 of microplexer k.
- cfg_loaded  output  1  level; high once at least one frame has been committed since reset.
- cfg_done  output  1  one-cycle pulse on a successful commit.
- cfg_err  output  1  one-cycle pulse on a checksum mismatch.

Behaviour:
- Reset (synchronous, active-high; sampled on the clk edge):
  - sel_flat=0, so every microplexer outputs 0.
  - cfg_loaded=0, cfg_done=0, cfg_err=0, cfg_ready=0.
  - State=HUNT; shadow register, byte counter and running XOR all cleared.
  - cfg_ready goes high in the first cycle after reset deasserts.
- Frame format: sync byte 0xA5, then NUM_MUX/2 payload bytes, then one checksum byte.
  - Payload byte j: low nibble -> mux 2j, high nibble -> mux 2j+1.
  - Checksum = XOR of all payload bytes. The sync byte is excluded.
- States:
  - HUNT: cfg_ready=1. An accepted byte equal to 0xA5 -> LOAD, with counter=0 and xor=0. Any other accepted byte is discarded and the state stays HUNT.
  - LOAD: cfg_ready=1. Each accepted byte is written to shadow[8j+7:8j] (j=counter), XORed into the running xor, and the counter increments. After byte NUM_MUX/2-1 is accepted -> CHECK. 0xA5 inside the payload is plain data and does not resync.
  - CHECK: cfg_ready=1. The accepted byte is compared with the running xor.
    - Match -> COMMIT.
    - Mismatch -> cfg_err=1 for the next cycle, state -> HUNT, shadow discarded, sel_flat and cfg_loaded unchanged.
  - COMMIT: one cycle with cfg_ready=0; bytes offered here are not consumed and the host must hold them. At the edge ending COMMIT: sel_flat<=shadow, cfg_loaded<=1, cfg_done=1 for the following cycle, state -> HUNT.
- Latency: checksum byte accepted at edge t -> sel_flat updates at edge t+1 -> cfg_done is high in the cycle after edge t+1.
- sel_flat changes only at the COMMIT edge and updates all bits on that same edge.
- cfg_valid=0 in any state: no state change and no counter change. Idle gaps mid-frame are legal and have no timeout.
- Back-to-back frames: a sync byte may be accepted in the cycle immediately after COMMIT.
- Reset mid-frame: the partial frame is lost and sel_flat returns to 0. This holds even if a frame was committed earlier.
- cfg_done and cfg_err are never high in the same cycle.
- Counter width is clog2(NUM_MUX/2)+1. Wrap-around is impossible because the counter is bounded by the LOAD exit.

Test Plan (NUM_MUX=8):
1. Reset, then send A5,21,43,65,87,80 -> cfg_done pulses once, sel_flat=0x87654321, cfg_loaded=1, cfg_ready low for exactly one cycle after byte 80.
2. After test 1, send A5,FF,FF,FF,FF,81 (correct checksum 00) -> cfg_err pulses once, sel_flat stays 0x87654321, no cfg_done.
3. Send 00,5A,13 and then a valid frame A5,11,11,11,11,00 -> the leading bytes are ignored, sel_flat=0x11111111.
4. Frame with payload A5,A5,A5,A5 (sequence A5,A5,A5,A5,A5,00), including random cfg_valid gaps -> payload A5 treated as data, sel_flat=0xA5A5A5A5.
5. Assert reset after sync plus two payload bytes -> sel_flat=0, cfg_loaded=0, no pulses; a subsequent full valid frame then commits normally.
6. Two valid frames back-to-back with cfg_valid held high throughout -> two cfg_done pulses, the final sel_flat equals the second frame, and the byte held during the COMMIT cycle is not lost.
